// File: rtl/screen_write_arbiter_if.sv
// Write-port bundle for screen_write_arbiter: character path, fill command and screen-buffer write.
// slave = arbiter view, master = surrounding logic / bench view.
interface screen_write_arbiter_if;
    logic       char_valid;
    logic       char_ready;
    logic [4:0] char_row;
    logic [6:0] char_col;
    logic [7:0] char_byte;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [4:0] cmd_row;
    logic [6:0] cmd_col;

    logic       buf_valid;
    logic       buf_ready;
    logic [4:0] buf_row;
    logic [6:0] buf_col;
    logic [7:0] buf_byte;

    logic       fill_busy;

    modport slave (
        input  char_valid, char_row, char_col, char_byte,
        output char_ready,
        input  cmd_valid, cmd_op, cmd_row, cmd_col,
        output cmd_ready,
        output buf_valid, buf_row, buf_col, buf_byte,
        input  buf_ready,
        output fill_busy
    );

    modport master (
        output char_valid, char_row, char_col, char_byte,
        input  char_ready,
        output cmd_valid, cmd_op, cmd_row, cmd_col,
        input  cmd_ready,
        input  buf_valid, buf_row, buf_col, buf_byte,
        output buf_ready,
        input  fill_busy
    );
endinterface

// File: rtl/screen_write_arbiter.sv
// Shares the screen-buffer write port between the character path and a clear/fill engine.
// Define SCREEN_ARB_CLEAR_EOL_EN to enable op 10 (clear from cmd_col to end of row).
//
// state | meaning
// IDLE  | character path passes straight through to the buffer port; commands accepted
// FILL  | buffer port owned by fill engine, writing FILL_BYTE cell by cell
module screen_write_arbiter #(
    parameter int         ROWS      = 24,
    parameter int         COLS      = 100,
    parameter logic [7:0] FILL_BYTE = 8'h20
) (
    input logic                   clk,
    input logic                   reset,
    screen_write_arbiter_if.slave bus
);

`ifdef SCREEN_ARB_CLEAR_EOL_EN
    localparam bit EOL_EN = 1'b1;
`else
    localparam bit EOL_EN = 1'b0;
`endif

    localparam logic [5:0] ROWS_L   = 6'(ROWS);
    localparam logic [7:0] COLS_L   = 8'(COLS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t     state;
    logic [4:0] row_q;
    logic [6:0] col_q;
    logic [4:0] end_row;

    logic       fill_on;
    logic       range_ok;
    logic       start_fill;
    logic [4:0] start_row;
    logic [6:0] start_col;
    logic [4:0] start_end;
    logic       last_cell;

    // Out-of-range row/col rejects every op, clear-screen included.
    always_comb begin
        range_ok   = ({1'b0, bus.cmd_row} < ROWS_L) && ({1'b0, bus.cmd_col} < COLS_L);
        start_fill = 1'b0;
        start_row  = 5'd0;
        start_col  = 7'd0;
        start_end  = 5'd0;
        case (bus.cmd_op)
            2'b00: begin
                start_fill = range_ok;
                start_end  = LAST_ROW;
            end
            2'b01: begin
                start_fill = range_ok;
                start_row  = bus.cmd_row;
                start_end  = bus.cmd_row;
            end
            2'b10: begin
                start_fill = EOL_EN && range_ok;
                start_row  = bus.cmd_row;
                start_col  = bus.cmd_col;
                start_end  = bus.cmd_row;
            end
            default: start_fill = 1'b0;
        endcase
    end

    assign last_cell = (row_q == end_row) && (col_q == LAST_COL);

    // Reset masks the fill side immediately so an aborted fill issues no further writes.
    assign fill_on       = (state == FILL) && !reset;
    assign bus.fill_busy = fill_on;
    assign bus.cmd_ready = (state == IDLE) && !reset;

    always_comb begin
        if (fill_on) begin
            bus.buf_valid  = 1'b1;
            bus.buf_row    = row_q;
            bus.buf_col    = col_q;
            bus.buf_byte   = FILL_BYTE;
            bus.char_ready = 1'b0;
        end else begin
            bus.buf_valid  = bus.char_valid;
            bus.buf_row    = bus.char_row;
            bus.buf_col    = bus.char_col;
            bus.buf_byte   = bus.char_byte;
            bus.char_ready = bus.buf_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            row_q   <= 5'd0;
            col_q   <= 7'd0;
            end_row <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && start_fill) begin
                        state   <= FILL;
                        row_q   <= start_row;
                        col_q   <= start_col;
                        end_row <= start_end;
                    end
                end
                FILL: begin
                    if (bus.buf_ready) begin
                        if (last_cell) begin
                            state <= IDLE;
                        end else if (col_q == LAST_COL) begin
                            col_q <= 7'd0;
                            row_q <= row_q + 5'd1;
                        end else begin
                            col_q <= col_q + 7'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_write_arbiter.sv
// Directed bench for screen_write_arbiter: pass-through vectors plus fill, abort and command-reject sequences.
module tb_screen_write_arbiter;
    localparam int ROWS = 24;
    localparam int COLS = 100;
    localparam logic [7:0] FILL = 8'h20;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    screen_write_arbiter_if bus ();

    screen_write_arbiter #(.ROWS(ROWS), .COLS(COLS), .FILL_BYTE(FILL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [4:0] r;
        logic [6:0] c;
        logic [7:0] b;
        logic       br;
        logic       exp_bv;
        logic       exp_cr;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [4:0] r, input logic [6:0] c);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_row   = r;
        bus.cmd_col   = c;
        @(negedge clk);
        chk("cmd_ready_at_accept", 32'(bus.cmd_ready), 32'd1);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    // Expects n fill writes starting at (r,c), row-major; returns at posedge+1 after the last transfer.
    task automatic do_fill(input int n, input int r, input int c, input bit toggle);
        int got = 0;
        int cyc = 0;
        int er  = r;
        int ec  = c;
        while (got < n && cyc < 4 * n + 10) begin
            bus.buf_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            chk("fill_buf_valid", 32'(bus.buf_valid), 32'd1);
            chk("fill_busy", 32'(bus.fill_busy), 32'd1);
            chk("fill_char_ready", 32'(bus.char_ready), 32'd0);
            chk("fill_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("fill_row", 32'(bus.buf_row), 32'(er));
            chk("fill_col", 32'(bus.buf_col), 32'(ec));
            chk("fill_byte", 32'(bus.buf_byte), 32'(FILL));
            if (bus.buf_ready) begin
                got++;
                if (ec == COLS - 1) begin
                    ec = 0;
                    er++;
                end else begin
                    ec++;
                end
            end
            cyc++;
            step();
        end
        bus.buf_ready = 1'b1;
        if (got < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fill_timeout: got %0d writes expected %0d", got, n);
        end
    endtask

    task automatic expect_no_writes(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("quiet_buf_valid", 32'(bus.buf_valid), 32'd0);
            chk("quiet_fill_busy", 32'(bus.fill_busy), 32'd0);
            chk("quiet_cmd_ready", 32'(bus.cmd_ready), 32'd1);
            step();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset          = 1'b1;
        bus.char_valid = 1'b0;
        bus.char_row   = 5'd0;
        bus.char_col   = 7'd0;
        bus.char_byte  = 8'd0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_row    = 5'd0;
        bus.cmd_col    = 7'd0;
        bus.buf_ready  = 1'b1;

        vecs[0] = '{1'b1, 5'd3,  7'd7,  8'h41, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 5'd3,  7'd7,  8'h41, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 5'd10, 7'd50, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 5'd23, 7'd99, 8'hff, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 5'd0,  7'd0,  8'h7e, 1'b0, 1'b1, 1'b0};

        // Reset state
        @(negedge clk);
        chk("rst_fill_busy", 32'(bus.fill_busy), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("idle_fill_busy", 32'(bus.fill_busy), 32'd0);
        step();

        // IDLE pass-through vectors
        foreach (vecs[i]) begin
            bus.char_valid = vecs[i].cv;
            bus.char_row   = vecs[i].r;
            bus.char_col   = vecs[i].c;
            bus.char_byte  = vecs[i].b;
            bus.buf_ready  = vecs[i].br;
            @(negedge clk);
            chk("vec_buf_valid", 32'(bus.buf_valid), 32'(vecs[i].exp_bv));
            chk("vec_char_ready", 32'(bus.char_ready), 32'(vecs[i].exp_cr));
            chk("vec_buf_row", 32'(bus.buf_row), 32'(vecs[i].r));
            chk("vec_buf_col", 32'(bus.buf_col), 32'(vecs[i].c));
            chk("vec_buf_byte", 32'(bus.buf_byte), 32'(vecs[i].b));
            step();
        end
        bus.char_valid = 1'b0;
        bus.buf_ready  = 1'b1;

        // Clear screen: full range, back to idle afterwards
        issue_cmd(2'b00, 5'd0, 7'd0);
        do_fill(ROWS * COLS, 0, 0, 1'b0);
        expect_no_writes(2);

        // Clear row 5 with stalling buffer
        issue_cmd(2'b01, 5'd5, 7'd0);
        do_fill(COLS, 5, 0, 1'b1);
        expect_no_writes(1);

        // Character and command on the same cycle; held character during fill
        bus.char_valid = 1'b1;
        bus.char_row   = 5'd4;
        bus.char_col   = 7'd10;
        bus.char_byte  = 8'h61;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = 2'b01;
        bus.cmd_row    = 5'd1;
        bus.cmd_col    = 7'd0;
        @(negedge clk);
        chk("same_cyc_buf_valid", 32'(bus.buf_valid), 32'd1);
        chk("same_cyc_buf_row", 32'(bus.buf_row), 32'd4);
        chk("same_cyc_buf_col", 32'(bus.buf_col), 32'd10);
        chk("same_cyc_buf_byte", 32'(bus.buf_byte), 32'h61);
        chk("same_cyc_char_ready", 32'(bus.char_ready), 32'd1);
        chk("same_cyc_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        step();
        bus.cmd_valid = 1'b0;
        bus.char_row  = 5'd6;
        bus.char_col  = 7'd20;
        bus.char_byte = 8'h62;
        do_fill(COLS, 1, 0, 1'b0);
        @(negedge clk);
        chk("held_char_buf_valid", 32'(bus.buf_valid), 32'd1);
        chk("held_char_row", 32'(bus.buf_row), 32'd6);
        chk("held_char_col", 32'(bus.buf_col), 32'd20);
        chk("held_char_byte", 32'(bus.buf_byte), 32'h62);
        chk("held_char_ready", 32'(bus.char_ready), 32'd1);
        step();
        bus.char_valid = 1'b0;

        // Reset mid-fill
        issue_cmd(2'b00, 5'd0, 7'd0);
        do_fill(50, 0, 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rst_fill_busy", 32'(bus.fill_busy), 32'd0);
        chk("abort_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("abort_rst_buf_valid", 32'(bus.buf_valid), 32'd0);
        step();
        reset          = 1'b0;
        bus.char_valid = 1'b1;
        bus.char_row   = 5'd7;
        bus.char_col   = 7'd9;
        bus.char_byte  = 8'h55;
        @(negedge clk);
        chk("abort_buf_valid", 32'(bus.buf_valid), 32'd1);
        chk("abort_buf_row", 32'(bus.buf_row), 32'd7);
        chk("abort_buf_byte", 32'(bus.buf_byte), 32'h55);
        chk("abort_fill_busy", 32'(bus.fill_busy), 32'd0);
        step();
        bus.char_valid = 1'b0;
        expect_no_writes(3);

        // Clear to end of row
        issue_cmd(2'b10, 5'd2, 7'd95);
`ifdef SCREEN_ARB_CLEAR_EOL_EN
        do_fill(COLS - 95, 2, 95, 1'b0);
        expect_no_writes(1);
`else
        expect_no_writes(3);
`endif

        // Rejected commands: reserved op, out-of-range row and column
        issue_cmd(2'b11, 5'd0, 7'd0);
        expect_no_writes(2);
        issue_cmd(2'b01, 5'd24, 7'd0);
        expect_no_writes(2);
        issue_cmd(2'b00, 5'd24, 7'd0);
        expect_no_writes(2);
        issue_cmd(2'b01, 5'd3, 7'd100);
        expect_no_writes(2);

        // Last row still accepted
        issue_cmd(2'b01, 5'd23, 7'd0);
        do_fill(COLS, 23, 0, 1'b0);
        expect_no_writes(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
